ibex_mem_arbiter: RTL and testbench
===================================

# ibex_mem_arbiter

Two-to-one memory-port arbiter that lets the Ibex instruction-fetch interface and data interface share one external memory port using the req/gnt/rvalid bus protocol. It sits between `ibex_top` and a single-ported memory or interconnect. It forwards one granted request per cycle and tracks outstanding transactions in an in-order ID FIFO. Each rvalid response is routed back to the requester that issued it, with zero added latency on request and response paths.

## Interface
- `MaxOutstanding`, default 2: maximum in-flight transactions (1..8); depth of the ID FIFO.
- `ErrOnStray`, default 1: when 1, a response with no outstanding transaction sets `proto_err_o`.

Ports (clock and reset first):
- `clk_i` input 1: clock; all state updates on the rising edge.
- `rst_i` input 1: reset, synchronous, active-high.
- `instr_req_i` input 1, `instr_addr_i` input 32: fetch request (read-only).
- `instr_gnt_o` output 1, `instr_rvalid_o` output 1, `instr_rdata_o` output 32, `instr_err_o` output 1: fetch response side.
- `data_req_i` input 1, `data_we_i` input 1, `data_be_i` input 4, `data_addr_i` input 32, `data_wdata_i` input 32: LSU request.
- `data_gnt_o` output 1, `data_rvalid_o` output 1, `data_rdata_o` output 32, `data_err_o` output 1: LSU response side.
- `mem_req_o` output 1, `mem_we_o` output 1, `mem_be_o` output 4, `mem_addr_o` output 32, `mem_wdata_o` output 32: shared port request.
- `mem_gnt_i` input 1, `mem_rvalid_i` input 1, `mem_rdata_i` input 32, `mem_err_i` input 1: shared port response.
- `proto_err_o` output 1: sticky stray-response flag; cleared only by reset.

## Operation
- **Selection.** Each cycle `sel` is one of {INSTR, DATA} among requesters with req high.
- **Lock.** Lock state ARB_FREE/ARB_LOCKED. `mem_req_o` high without `mem_gnt_i` moves ARB_FREE to ARB_LOCKED and holds `sel`. `mem_gnt_i` returns to ARB_FREE. A presented request and its address/data never change before grant.
- **Request mux.** `mem_req_o = req[sel] && count < MaxOutstanding`. `mem_addr_o`, `mem_wdata_o`, `mem_be_o` and `mem_we_o` come from `sel`. An instr request drives `mem_we_o`=0 and `mem_be_o`=4'hF.
- **Grant.** `<sel>_gnt_o = mem_gnt_i && mem_req_o` (combinational). The non-selected requester's gnt is 0.
- **ID FIFO.** On grant, push `sel` (1 bit). On `mem_rvalid_i`, pop the head. Simultaneous push and pop keeps `count` unchanged; pointers wrap modulo `MaxOutstanding`. `count` is `$clog2(MaxOutstanding+1)` bits.
- **Response.** Route `mem_rvalid_i` and `mem_err_i` to the requester at the FIFO head. `mem_rdata_i` is broadcast to both rdata outputs unqualified.
- **Stray response.** `mem_rvalid_i` with `count`=0 is dropped: no rvalid out, no pop. `proto_err_o` is set if `ErrOnStray`.
- **Full.** At `count == MaxOutstanding`, `mem_req_o`=0 and both gnts are 0 until a pop. A pop in the same cycle does not unblock that cycle.
- **Reset mid-operation.** FIFO empties and the lock clears. Responses to pre-reset transactions are treated as stray.

## Timing
- Reset values: `mem_req_o`=0, all gnt/rvalid/err outputs 0, `proto_err_o`=0, `count`=0, lock=ARB_FREE, RR pointer favours INSTR.
- Request path is combinational: 0-cycle added latency, request to `mem_req_o`.
- Response path is combinational from `mem_rvalid_i` and the registered FIFO head: 0-cycle added latency.
- Back-to-back grants are allowed every cycle while `count < MaxOutstanding`.
- Responses are in order. The memory must return rvalid in grant order, at the earliest the cycle after grant.

## Configuration
- `IBEX_MEM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-granted pointer updates on every grant.
  - When both requesters are pending in ARB_FREE, the one not last granted wins.
- Not defined: fixed priority, DATA over INSTR. The pointer is not implemented.
- The lock rule applies in both modes.

## Test plan
- **Single fetch.** `instr_req_i`=1, addr 0x100; `mem_gnt_i`=1 same cycle; rvalid next cycle with rdata 0xDEADBEEF -> `instr_gnt_o`=1 at cycle 0; `instr_rvalid_o`=1, `instr_rdata_o`=0xDEADBEEF at cycle 1; `data_rvalid_o`=0.
- **Lock hold.** `instr_req_i` asserted, `mem_gnt_i` low 3 cycles; `data_req_i` rises in cycle 1 -> `mem_addr_o` stays at instr addr until grant; data granted the cycle after.
- **Contention (both on, fixed priority).** Both requesting every cycle, `MaxOutstanding`=2, immediate gnt -> grant order D,D,... in fixed mode; I,D,I,D with `IBEX_MEM_ARB_RR_EN`. Responses route per FIFO order.
- **Full.** 2 grants with no rvalid -> third request sees `mem_req_o`=0; rvalid in cycle N -> `mem_req_o`=1 in cycle N+1.
- **Stray.** `mem_rvalid_i`=1 with `count`=0 -> no rvalid out; `proto_err_o`=1 and stays 1 until `rst_i`.
- **Reset mid-flight.** 1 outstanding data read, `rst_i` pulsed, then rvalid -> `data_rvalid_o`=0, `proto_err_o`=1.

Source files
------------

// File: rtl/ibex_mem_arbiter.sv
// ibex_mem_arbiter: shares one req/gnt/rvalid memory port between Ibex fetch and LSU.
// Latency: 0 cycles added on request and response; responses are routed by an in-order ID FIFO.
// Backpressure: a stalled grant locks the selection; no request issues while MaxOutstanding are in flight.
// Build option IBEX_MEM_ARB_RR_EN selects round-robin; default is fixed DATA-over-INSTR priority.

module ibex_mem_arbiter_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 1,
    parameter int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [Width-1:0] push_dat,
    input  logic             pop,
    output logic [Width-1:0] head_dat,
    output logic [CntW-1:0]  count
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;

    // Pointers wrap at Depth so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
endmodule

module ibex_mem_arbiter #(
    parameter int unsigned MaxOutstanding = 2,
    parameter bit          ErrOnStray     = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_err_i,
    output logic        proto_err_o
);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    typedef enum logic {ARB_FREE   = 1'b0, ARB_LOCKED = 1'b1} lock_e;
    typedef enum logic {SEL_INSTR  = 1'b0, SEL_DATA   = 1'b1} sel_e;

    lock_e           lock_q, lock_d;
    sel_e            lock_sel_q, lock_sel_d;
    sel_e            sel;
    logic            sel_req;
    logic            grant;
    logic            pop;
    logic            stray;
    logic            not_full;
    logic [0:0]      head_id;
    logic [CntW-1:0] count;
    logic            proto_err_q;

`ifdef IBEX_MEM_ARB_RR_EN
    sel_e            last_q;

    // Reset to DATA so INSTR wins the first contended cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= SEL_DATA;
        end else if (grant) begin
            last_q <= sel;
        end
    end
`endif

    always_comb begin
        sel = SEL_INSTR;
        if (lock_q == ARB_LOCKED) begin
            sel = lock_sel_q;
        end else if (instr_req_i && data_req_i) begin
`ifdef IBEX_MEM_ARB_RR_EN
            sel = (last_q == SEL_INSTR) ? SEL_DATA : SEL_INSTR;
`else
            sel = SEL_DATA;
`endif
        end else if (data_req_i) begin
            sel = SEL_DATA;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lock_q     <= ARB_FREE;
            lock_sel_q <= SEL_INSTR;
        end else begin
            lock_q     <= lock_d;
            lock_sel_q <= lock_sel_d;
        end
    end

    // A presented-but-ungranted request pins the selection until the grant arrives.
    always_comb begin
        lock_d     = lock_q;
        lock_sel_d = lock_sel_q;
        if (mem_gnt_i) begin
            lock_d = ARB_FREE;
        end else if (mem_req_o) begin
            lock_d     = ARB_LOCKED;
            lock_sel_d = sel;
        end
    end

    assign not_full    = (count < CntW'(MaxOutstanding));
    assign sel_req     = (sel == SEL_DATA) ? data_req_i : instr_req_i;
    assign mem_req_o   = !rst_i && sel_req && not_full;
    assign grant       = mem_req_o && mem_gnt_i;
    assign instr_gnt_o = grant && (sel == SEL_INSTR);
    assign data_gnt_o  = grant && (sel == SEL_DATA);

    assign mem_we_o    = (sel == SEL_DATA) ? data_we_i    : 1'b0;
    assign mem_be_o    = (sel == SEL_DATA) ? data_be_i    : 4'hF;
    assign mem_addr_o  = (sel == SEL_DATA) ? data_addr_i  : instr_addr_i;
    assign mem_wdata_o = (sel == SEL_DATA) ? data_wdata_i : 32'h0;

    ibex_mem_arbiter_fifo #(
        .Depth (MaxOutstanding),
        .Width (1),
        .CntW  (CntW)
    ) u_id_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (grant),
        .push_dat (sel),
        .pop      (pop),
        .head_dat (head_id),
        .count    (count)
    );

    // Responses with nothing outstanding are dropped rather than popping an empty FIFO.
    assign pop   = !rst_i && mem_rvalid_i && (count != '0);
    assign stray = !rst_i && mem_rvalid_i && (count == '0);

    assign instr_rvalid_o = pop && (head_id == SEL_INSTR);
    assign data_rvalid_o  = pop && (head_id == SEL_DATA);
    assign instr_err_o    = instr_rvalid_o && mem_err_i;
    assign data_err_o     = data_rvalid_o && mem_err_i;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            proto_err_q <= 1'b0;
        end else if (ErrOnStray && stray) begin
            proto_err_q <= 1'b1;
        end
    end

    assign proto_err_o = proto_err_q;
endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Bench for ibex_mem_arbiter: directed test-plan scenarios then constrained-random traffic,
// all checked against a transaction-level model (outstanding-ID queue, lock flag, last-winner).

module tb_ibex_mem_arbiter;
    localparam int MAX          = 2;
    localparam bit ERR_ON_STRAY = 1'b1;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;
    logic        proto_err_o;

    always #5 clk = ~clk;

    ibex_mem_arbiter #(
        .MaxOutstanding (MAX),
        .ErrOnStray     (ERR_ON_STRAY)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_rdata_o  (instr_rdata_o),
        .instr_err_o    (instr_err_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_rdata_o   (data_rdata_o),
        .data_err_o     (data_err_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_gnt_i      (mem_gnt_i),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i),
        .mem_err_i      (mem_err_i),
        .proto_err_o    (proto_err_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = INSTR, 1 = DATA.
    int ids[$];
    bit locked;
    int lk_who;
    int last;
    bit perr;
    int who;
    bit exp_req, exp_ig, exp_dg, exp_irv, exp_drv, exp_ierr, exp_derr;
    bit ipend, dpend;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ids.delete();
        locked = 1'b0;
        lk_who = 0;
        last   = 1;
        perr   = 1'b0;
    endtask

    task automatic model_eval();
        exp_req = 0; exp_ig = 0; exp_dg = 0;
        exp_irv = 0; exp_drv = 0; exp_ierr = 0; exp_derr = 0;
        who = 0;
        if (!rst_i) begin
            if (locked) who = lk_who;
            else if (instr_req_i && data_req_i) begin
`ifdef IBEX_MEM_ARB_RR_EN
                who = (last == 1) ? 0 : 1;
`else
                who = 1;
`endif
            end else who = data_req_i ? 1 : 0;
            exp_req = (ids.size() < MAX) && ((who == 1) ? data_req_i : instr_req_i);
            exp_ig  = exp_req && mem_gnt_i && (who == 0);
            exp_dg  = exp_req && mem_gnt_i && (who == 1);
            if (mem_rvalid_i && ids.size() > 0) begin
                exp_irv  = (ids[0] == 0);
                exp_drv  = (ids[0] == 1);
                exp_ierr = exp_irv && mem_err_i;
                exp_derr = exp_drv && mem_err_i;
            end
        end
    endtask

    task automatic model_update();
        if (rst_i) model_reset();
        else begin
            if (mem_rvalid_i && ids.size() > 0) ids.delete(0);
            else if (mem_rvalid_i && ERR_ON_STRAY) perr = 1'b1;
            if (exp_req && mem_gnt_i) begin
                ids.push_back(who);
                last = who;
            end
            if (mem_gnt_i) locked = 1'b0;
            else if (exp_req) begin
                locked = 1'b1;
                lk_who = who;
            end
        end
    endtask

    // Called at the falling edge once inputs are driven.
    task automatic sample(input string tag);
        #1;
        model_eval();
        chk({tag, ".mem_req"},      mem_req_o,      exp_req);
        chk({tag, ".instr_gnt"},    instr_gnt_o,    exp_ig);
        chk({tag, ".data_gnt"},     data_gnt_o,     exp_dg);
        chk({tag, ".instr_rvalid"}, instr_rvalid_o, exp_irv);
        chk({tag, ".data_rvalid"},  data_rvalid_o,  exp_drv);
        chk({tag, ".instr_err"},    instr_err_o,    exp_ierr);
        chk({tag, ".data_err"},     data_err_o,     exp_derr);
        chk({tag, ".proto_err"},    proto_err_o,    perr);
        chk({tag, ".instr_rdata"},  instr_rdata_o,  mem_rdata_i);
        chk({tag, ".data_rdata"},   data_rdata_o,   mem_rdata_i);
        if (exp_req) begin
            chk({tag, ".mem_addr"}, mem_addr_o, (who == 1) ? data_addr_i : instr_addr_i);
            chk({tag, ".mem_we"},   mem_we_o,   (who == 1) ? data_we_i : 1'b0);
            chk({tag, ".mem_be"},   mem_be_o,   (who == 1) ? data_be_i : 4'hF);
            if (who == 1) chk({tag, ".mem_wdata"}, mem_wdata_o, data_wdata_i);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_err_i = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: end of stimulus not reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i = 1; idle_inputs();
        instr_addr_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
        mem_rdata_i = 0;
        model_reset();
        ipend = 0; dpend = 0;
        @(negedge clk);
        sample("reset"); advance();
        sample("reset2"); advance();
        rst_i = 0;

        // Single fetch
        instr_req_i = 1; instr_addr_i = 32'h100; mem_gnt_i = 1;
        sample("fetch_c0");
        chk("fetch_gnt_lit", instr_gnt_o, 1'b1);
        advance();
        instr_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
        sample("fetch_c1");
        chk("fetch_rvalid_lit", instr_rvalid_o, 1'b1);
        chk("fetch_rdata_lit", instr_rdata_o, 32'hDEADBEEF);
        chk("fetch_drvalid_lit", data_rvalid_o, 1'b0);
        advance();
        mem_rvalid_i = 0;

        // Lock hold: instr stalled three cycles, data arrives in cycle 1
        instr_req_i = 1; instr_addr_i = 32'h200;
        sample("lock_c0"); advance();
        data_req_i = 1; data_we_i = 1; data_be_i = 4'h3; data_addr_i = 32'h300; data_wdata_i = 32'h1234_5678;
        sample("lock_c1");
        chk("lock_addr_c1", mem_addr_o, 32'h200);
        advance();
        sample("lock_c2");
        chk("lock_addr_c2", mem_addr_o, 32'h200);
        advance();
        mem_gnt_i = 1;
        sample("lock_c3");
        chk("lock_igrant", instr_gnt_o, 1'b1);
        chk("lock_addr_c3", mem_addr_o, 32'h200);
        advance();
        instr_req_i = 0;
        sample("lock_c4");
        chk("lock_dgrant", data_gnt_o, 1'b1);
        chk("lock_daddr", mem_addr_o, 32'h300);
        advance();
        data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hA1;
        sample("lock_rsp0");
        chk("lock_rsp0_instr", instr_rvalid_o, 1'b1);
        advance();
        mem_rdata_i = 32'hA2; mem_err_i = 1;
        sample("lock_rsp1");
        chk("lock_rsp1_data", data_rvalid_o, 1'b1);
        chk("lock_rsp1_err", data_err_o, 1'b1);
        advance();
        idle_inputs();

        // Contention with immediate grants, then full
        instr_req_i = 1; instr_addr_i = 32'h400;
        data_req_i = 1; data_we_i = 0; data_be_i = 4'hF; data_addr_i = 32'h500; mem_gnt_i = 1;
        sample("cont_a");
`ifdef IBEX_MEM_ARB_RR_EN
        chk("cont_a_lit", instr_gnt_o, 1'b1);
`else
        chk("cont_a_lit", data_gnt_o, 1'b1);
`endif
        advance();
        sample("cont_b");
        chk("cont_b_lit", data_gnt_o, 1'b1);
        advance();
        mem_rvalid_i = 1; mem_rdata_i = 32'hC0;
        sample("cont_full");
        chk("full_blocks_req", mem_req_o, 1'b0);
        advance();
        mem_rvalid_i = 0;
        sample("cont_d");
        chk("full_unblocked", mem_req_o, 1'b1);
        advance();
        instr_req_i = 0; data_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hC1;
        sample("drain0"); advance();
        mem_rdata_i = 32'hC2;
        sample("drain1"); advance();

        // Stray response with nothing outstanding
        sample("stray");
        chk("stray_irv", instr_rvalid_o, 1'b0);
        chk("stray_drv", data_rvalid_o, 1'b0);
        advance();
        mem_rvalid_i = 0;
        for (int i = 0; i < 3; i++) begin
            sample("stray_hold");
            chk("stray_sticky", proto_err_o, 1'b1);
            advance();
        end
        rst_i = 1; sample("stray_rst"); advance(); rst_i = 0;
        sample("stray_cleared");
        chk("stray_cleared_lit", proto_err_o, 1'b0);
        advance();

        // Reset with one data read in flight
        data_req_i = 1; data_we_i = 0; data_addr_i = 32'h600; mem_gnt_i = 1;
        sample("mid_req");
        chk("mid_dgnt", data_gnt_o, 1'b1);
        advance();
        idle_inputs(); rst_i = 1;
        sample("mid_rst"); advance();
        rst_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h66;
        sample("mid_rsp");
        chk("mid_no_rvalid", data_rvalid_o, 1'b0);
        advance();
        mem_rvalid_i = 0;
        sample("mid_after");
        chk("mid_proto_err", proto_err_o, 1'b1);
        advance();
        rst_i = 1; sample("pre_rand_rst"); advance(); rst_i = 0;

        // Random traffic obeying the req/gnt/rvalid protocol
        for (int n = 0; n < 1500; n++) begin
            if (!ipend && $urandom_range(0, 99) < 50) begin
                ipend = 1;
                instr_addr_i = $urandom() & 32'hFFFF_FFFC;
            end
            if (!dpend && $urandom_range(0, 99) < 50) begin
                dpend = 1;
                data_we_i    = 1'($urandom_range(0, 1));
                data_be_i    = 4'($urandom_range(0, 15));
                data_addr_i  = $urandom() & 32'hFFFF_FFFC;
                data_wdata_i = $urandom();
            end
            instr_req_i  = ipend;
            data_req_i   = dpend;
            mem_gnt_i    = ($urandom_range(0, 99) < 65);
            mem_rvalid_i = (ids.size() > 0) && ($urandom_range(0, 99) < 50);
            mem_rdata_i  = $urandom();
            mem_err_i    = ($urandom_range(0, 9) == 0);
            sample("rand");
            if (exp_ig) ipend = 0;
            if (exp_dg) dpend = 0;
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
